sram_ctrl: RTL and testbench

- Synchronous controller for the board's 256K x 16 asynchronous SRAM; the stage directly upstream of the RAMCS/RAMWE/RAMOE/RAMUB/RAMLB/ADR/DAT pins of chip.
- Turns a valid/ready word-request interface from user logic into correctly sequenced SRAM read and write cycles.
- Returns read data with a one-cycle valid pulse.
- Owns the DAT tristate.

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_ctrl_if.sv | 34 +++
 rtl/sram_iobuf.sv | 18 +
 rtl/sram_ctrl.sv | 131 +++++++++++++
 tb/tb_sram_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM controller: default widths,
// FSM state encoding and the idle level of the SRAM control pins.
package sram_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  // Controller states; the value is exported on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } sram_state_t;

  // Control pin vector ordering: {RAMCS, RAMWE, RAMOE, RAMUB, RAMLB}.
  // All are active-low, so idle means every strobe deasserted.
  localparam logic [4:0] SRAM_IDLE_PINS = 5'b11111;

  // Larger of two cycle counts, used to size the shared down-counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// User-side word request / response bus of the SRAM controller.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. The requester keeps req_valid and its payload
// stable until that edge. rd_valid and wr_done are single-cycle pulses
// with no back-pressure.
interface sram_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_be;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_done;

  // User logic issuing requests.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rd_data, rd_valid, wr_done
  );

  // The controller serving requests.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rd_data, rd_valid, wr_done
  );

endinterface

// File: rtl/sram_iobuf.sv
// Bidirectional data pad buffer. All inout handling for the SRAM data bus
// lives here so it can be swapped for a vendor IO primitive in one place.
module sram_iobuf #(
  parameter int W = 16
) (
  input  logic         oe,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] pad
);

  // Drive the pad only when output-enabled, otherwise release it.
  assign pad = oe ? dout : {W{1'bz}};

  // The pad is always observable as input.
  assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous controller for a 256K x 16 asynchronous SRAM. Accepts word
// requests on a valid/ready bus and sequences registered SRAM pins for
// read cycles (RD) and write cycles (WR_SETUP -> WR_PULSE -> WR_HOLD).
// Every SRAM pin comes straight from a flop; req_* never reach pins
// combinationally.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              greset,
  sram_ctrl_if.slave        bus,
  output logic              RAMCS,
  output logic              RAMWE,
  output logic              RAMOE,
  output logic              RAMUB,
  output logic              RAMLB,
  output logic [ADDR_W-1:0] ADR,
  inout  wire  [DATA_W-1:0] DAT,
  output sram_state_t       dbg_state,
  output logic              dbg_dat_oe
);

  // Down-counter counts from N-1 to 0, so it needs to hold MAX_CYC-1.
  localparam int MAX_CYC = max_int(RD_CYCLES, WR_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  sram_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              dat_oe;
  logic [DATA_W-1:0] dat_out;
  logic [DATA_W-1:0] dat_in;

  sram_iobuf #(
    .W (DATA_W)
  ) u_iobuf (
    .oe   (dat_oe),
    .dout (dat_out),
    .din  (dat_in),
    .pad  (DAT)
  );

  // Ready is a pure decode of the state register, so it never depends on req_*.
  assign bus.req_ready = (state == ST_IDLE);
  assign dbg_state     = state;
  assign dbg_dat_oe    = dat_oe;

  // Request sequencing FSM with registered SRAM pins and response pulses.
  always_ff @(posedge clk) begin
    if (greset) begin
      state                             <= ST_IDLE;
      cnt                               <= '0;
      {RAMCS, RAMWE, RAMOE, RAMUB, RAMLB} <= SRAM_IDLE_PINS;
      ADR                               <= '0;
      dat_oe                            <= 1'b0;
      dat_out                           <= '0;
      bus.rd_data                       <= '0;
      bus.rd_valid                      <= 1'b0;
      bus.wr_done                       <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      bus.wr_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // In IDLE ready is high, so valid alone means accept.
          if (bus.req_valid) begin
            ADR   <= bus.req_addr;
            RAMCS <= 1'b0;
            RAMWE <= 1'b1;
            RAMUB <= ~bus.req_be[1];
            RAMLB <= ~bus.req_be[0];
            if (bus.req_we) begin
              // OE stays high for the whole write, so driving DAT is safe.
              RAMOE   <= 1'b1;
              dat_oe  <= 1'b1;
              dat_out <= bus.req_wdata;
              state   <= ST_WR_SETUP;
            end else begin
              RAMOE <= 1'b0;
              cnt   <= CNT_W'(RD_CYCLES - 1);
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (cnt == '0) begin
            bus.rd_data                       <= dat_in;
            bus.rd_valid                      <= 1'b1;
            {RAMCS, RAMWE, RAMOE, RAMUB, RAMLB} <= SRAM_IDLE_PINS;
            ADR                               <= '0;
            state                             <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR_SETUP: begin
          RAMWE <= 1'b0;
          cnt   <= CNT_W'(WR_CYCLES - 1);
          state <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (cnt == '0) begin
            RAMWE <= 1'b1;
            state <= ST_WR_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR_HOLD: begin
          // Address and data were held through the WE rising edge; release now.
          {RAMCS, RAMWE, RAMOE, RAMUB, RAMLB} <= SRAM_IDLE_PINS;
          ADR                               <= '0;
          dat_oe                            <= 1'b0;
          bus.wr_done                       <= 1'b1;
          state                             <= ST_IDLE;
        end
        default: begin
          {RAMCS, RAMWE, RAMOE, RAMUB, RAMLB} <= SRAM_IDLE_PINS;
          ADR                               <= '0;
          dat_oe                            <= 1'b0;
          state                             <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: address-echo SRAM model on the data bus,
// directed scenarios plus randomized transactions checked against a
// per-cycle pin timeline derived from the request alone.
module tb_sram_ctrl;
  import sram_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int RD = 2;
  localparam int WR = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic greset = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          ramcs, ramwe, ramoe, ramub, ramlb;
  logic [AW-1:0] adr;
  wire  [DW-1:0] dat;
  sram_state_t   dbg_state;
  logic          dbg_dat_oe;

  sram_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RD), .WR_CYCLES(WR)
  ) dut (
    .clk        (clk),
    .greset     (greset),
    .bus        (bus),
    .RAMCS      (ramcs),
    .RAMWE      (ramwe),
    .RAMOE      (ramoe),
    .RAMUB      (ramub),
    .RAMLB      (ramlb),
    .ADR        (adr),
    .DAT        (dat),
    .dbg_state  (dbg_state),
    .dbg_dat_oe (dbg_dat_oe)
  );

  // Address-echo SRAM: on a read, each enabled lane returns ADR[15:0].
  assign dat[7:0]  = (!ramcs && !ramoe && !ramlb) ? adr[7:0]  : 8'bz;
  assign dat[15:8] = (!ramcs && !ramoe && !ramub) ? adr[15:8] : 8'bz;

  int cmp_n  = 0;
  int fail_n = 0;

  // ---------------- trace of one transaction ----------------
  logic [4:0]    tr_pins [0:15];
  logic [AW-1:0] tr_adr  [0:15];
  logic [DW-1:0] tr_dat  [0:15];
  logic [DW-1:0] tr_rdat [0:15];
  logic          tr_drv  [0:15];
  logic          tr_rv   [0:15];
  logic          tr_wd   [0:15];
  logic          tr_rdy  [0:15];
  int            tr_wait;
  bit            tr_ok;

  // ---------------- reference model ----------------
  // Clocks a request occupies the controller before its response pulse.
  function automatic int m_len(input bit we);
    return we ? WR + 2 : RD;
  endfunction

  // Expected {CS,WE,OE,UB,LB} k clocks after the accept edge.
  function automatic logic [4:0] m_pins(input bit we, input logic [1:0] be, input int k);
    if (k >= m_len(we)) return 5'b11111;
    if (!we) return {1'b0, 1'b1, 1'b0, ~be[1], ~be[0]};
    return {1'b0, (k >= 1 && k <= WR) ? 1'b0 : 1'b1, 1'b1, ~be[1], ~be[0]};
  endfunction

  function automatic logic m_drive(input bit we, input int k);
    return we && (k < m_len(we));
  endfunction

  function automatic logic [DW-1:0] m_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  // ---------------- driver ----------------
  // Call at a negedge. Presents the request, waits (bounded) for the accept,
  // then records samples k=0..len at successive negedges. Returns at the
  // negedge of the response clock. With hold=1 req_valid stays asserted.
  task automatic txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [1:0] be, input bit hold);
    int len;
    len = m_len(we);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    tr_wait = 0;
    tr_ok   = 1'b1;
    while (!bus.req_ready) begin
      if (tr_wait >= 50) begin
        cmp_n++; fail_n++;
        $display("FAIL accept_timeout: ready got 0 for %0d cycles want 1", tr_wait);
        bus.req_valid = 1'b0;
        tr_ok = 1'b0;
        return;
      end
      @(negedge clk);
      tr_wait++;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) @(negedge clk);
      tr_pins[k] = {ramcs, ramwe, ramoe, ramub, ramlb};
      tr_adr[k]  = adr;
      tr_dat[k]  = dat;
      tr_drv[k]  = dbg_dat_oe;
      tr_rv[k]   = bus.rd_valid;
      tr_wd[k]   = bus.wr_done;
      tr_rdy[k]  = bus.req_ready;
      tr_rdat[k] = bus.rd_data;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    greset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_be = 2'b00;
    repeat (10) @(negedge clk);
    greset = 1'b0;
    cmp_n++; if ({ramcs, ramwe, ramoe, ramub, ramlb} !== 5'b11111) begin fail_n++;
      $display("FAIL reset_pins: got %b want 11111", {ramcs, ramwe, ramoe, ramub, ramlb}); end
    cmp_n++; if (adr !== '0) begin fail_n++; $display("FAIL reset_adr: got %h want 0", adr); end
    cmp_n++; if (dbg_dat_oe !== 1'b0) begin fail_n++; $display("FAIL reset_dat_oe: got %b want 0", dbg_dat_oe); end
    cmp_n++; if (bus.rd_data !== '0) begin fail_n++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    cmp_n++; if ({bus.rd_valid, bus.wr_done} !== 2'b00) begin fail_n++;
      $display("FAIL reset_pulses: got %b want 00", {bus.rd_valid, bus.wr_done}); end
    cmp_n++; if (bus.req_ready !== 1'b1) begin fail_n++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    cmp_n++; if (dbg_state !== ST_IDLE) begin fail_n++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_read;
    txn(1'b0, 18'h3ABCD, 16'h0000, 2'b11, 1'b0);
    if (!tr_ok) return;
    for (int k = 0; k < RD; k++) begin
      cmp_n++; if (tr_pins[k] !== 5'b01000) begin fail_n++;
        $display("FAIL read_pins k=%0d: got %b want 01000", k, tr_pins[k]); end
      cmp_n++; if (tr_adr[k] !== 18'h3ABCD) begin fail_n++;
        $display("FAIL read_adr k=%0d: got %h want 3abcd", k, tr_adr[k]); end
      cmp_n++; if (tr_rv[k] !== 1'b0) begin fail_n++;
        $display("FAIL read_early_valid k=%0d: got %b want 0", k, tr_rv[k]); end
    end
    cmp_n++; if (tr_rv[RD] !== 1'b1) begin fail_n++; $display("FAIL read_valid: got %b want 1", tr_rv[RD]); end
    cmp_n++; if (tr_rdat[RD] !== 16'hABCD) begin fail_n++;
      $display("FAIL read_data: got %h want abcd", tr_rdat[RD]); end
    cmp_n++; if (tr_pins[RD] !== 5'b11111) begin fail_n++;
      $display("FAIL read_idle_pins: got %b want 11111", tr_pins[RD]); end
  endtask

  task automatic test_byte_read;
    txn(1'b0, 18'h01234, 16'h0000, 2'b01, 1'b0);
    if (!tr_ok) return;
    cmp_n++; if (tr_pins[0] !== 5'b01010) begin fail_n++;
      $display("FAIL byte_read_strobes: got %b want 01010", tr_pins[0]); end
    cmp_n++; if (tr_rdat[RD][7:0] !== 8'h34) begin fail_n++;
      $display("FAIL byte_read_low: got %h want 34", tr_rdat[RD][7:0]); end
    cmp_n++; if (tr_rv[RD] !== 1'b1) begin fail_n++; $display("FAIL byte_read_valid: got %b want 1", tr_rv[RD]); end
  endtask

  task automatic test_write;
    logic [4:0] exp;
    txn(1'b1, 18'h00010, 16'h55AA, 2'b11, 1'b0);
    if (!tr_ok) return;
    for (int k = 0; k <= WR + 2; k++) begin
      exp = (k == 0 || k == WR + 1) ? 5'b01100 : (k <= WR) ? 5'b00100 : 5'b11111;
      cmp_n++; if (tr_pins[k] !== exp) begin fail_n++;
        $display("FAIL write_pins k=%0d: got %b want %b", k, tr_pins[k], exp); end
      cmp_n++; if (tr_drv[k] !== (k <= WR + 1)) begin fail_n++;
        $display("FAIL write_drive k=%0d: got %b want %b", k, tr_drv[k], k <= WR + 1); end
      if (k <= WR + 1) begin
        cmp_n++; if (tr_dat[k] !== 16'h55AA) begin fail_n++;
          $display("FAIL write_dat k=%0d: got %h want 55aa", k, tr_dat[k]); end
        cmp_n++; if (tr_adr[k] !== 18'h00010) begin fail_n++;
          $display("FAIL write_adr k=%0d: got %h want 00010", k, tr_adr[k]); end
      end
      cmp_n++; if (tr_wd[k] !== (k == WR + 2)) begin fail_n++;
        $display("FAIL write_done k=%0d: got %b want %b", k, tr_wd[k], k == WR + 2); end
    end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] ra;
    ra = AW'($urandom_range(0, (1 << AW) - 1));
    txn(1'b1, AW'($urandom_range(0, (1 << AW) - 1)), 16'($urandom), 2'b11, 1'b1);
    if (!tr_ok) return;
    for (int k = 0; k <= WR + 2; k++) begin
      cmp_n++; if (tr_drv[k] && !tr_pins[k][2]) begin fail_n++;
        $display("FAIL b2b_contention k=%0d: got drive=1 oe=0 want no overlap", k); end
      cmp_n++; if (tr_rdy[k] !== (k == WR + 2)) begin fail_n++;
        $display("FAIL b2b_ready k=%0d: got %b want %b", k, tr_rdy[k], k == WR + 2); end
    end
    txn(1'b0, ra, 16'h0000, 2'b11, 1'b0);
    if (!tr_ok) return;
    cmp_n++; if (tr_wait !== 0) begin fail_n++;
      $display("FAIL b2b_accept_wait: got %0d want 0", tr_wait); end
    cmp_n++; if (tr_rdat[RD] !== ra[15:0]) begin fail_n++;
      $display("FAIL b2b_read_data: got %h want %h", tr_rdat[RD], ra[15:0]); end
  endtask

  task automatic test_stall;
    logic [AW-1:0] ra;
    ra = AW'($urandom_range(0, (1 << AW) - 1));
    txn(1'b0, ra, 16'h0000, 2'b11, 1'b1);
    if (!tr_ok) return;
    for (int k = 0; k < RD; k++) begin
      cmp_n++; if (tr_rdy[k] !== 1'b0) begin fail_n++;
        $display("FAIL stall_ready k=%0d: got %b want 0", k, tr_rdy[k]); end
    end
    cmp_n++; if (tr_pins[RD] !== 5'b11111) begin fail_n++;
      $display("FAIL stall_no_reaccept: got %b want 11111", tr_pins[RD]); end
    txn(1'b0, ra, 16'h0000, 2'b11, 1'b0);
    if (!tr_ok) return;
    cmp_n++; if (tr_wait !== 0) begin fail_n++; $display("FAIL stall_accept_wait: got %0d want 0", tr_wait); end
    cmp_n++; if (tr_rv[RD] !== 1'b1 || tr_rdat[RD] !== ra[15:0]) begin fail_n++;
      $display("FAIL stall_second_read: got %b/%h want 1/%h", tr_rv[RD], tr_rdat[RD], ra[15:0]); end
  endtask

  task automatic test_reset_mid_write;
    logic [AW-1:0] ra;
    bus.req_we = 1'b1; bus.req_addr = AW'($urandom_range(0, (1 << AW) - 1));
    bus.req_wdata = 16'($urandom); bus.req_be = 2'b11; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    cmp_n++; if (ramwe !== 1'b0) begin fail_n++; $display("FAIL rstw_in_pulse: got we=%b want 0", ramwe); end
    greset = 1'b1;
    @(negedge clk);
    cmp_n++; if ({ramcs, ramwe, ramoe, ramub, ramlb} !== 5'b11111) begin fail_n++;
      $display("FAIL rstw_pins: got %b want 11111", {ramcs, ramwe, ramoe, ramub, ramlb}); end
    cmp_n++; if (dbg_dat_oe !== 1'b0) begin fail_n++; $display("FAIL rstw_dat_oe: got %b want 0", dbg_dat_oe); end
    cmp_n++; if (adr !== '0) begin fail_n++; $display("FAIL rstw_adr: got %h want 0", adr); end
    greset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cmp_n++; if (bus.wr_done !== 1'b0) begin fail_n++; $display("FAIL rstw_no_done k=%0d: got 1 want 0", k); end
      @(negedge clk);
    end
    ra = AW'($urandom_range(0, (1 << AW) - 1));
    txn(1'b0, ra, 16'h0000, 2'b11, 1'b0);
    if (!tr_ok) return;
    cmp_n++; if (tr_rv[RD] !== 1'b1 || tr_rdat[RD] !== ra[15:0]) begin fail_n++;
      $display("FAIL rstw_next_read: got %b/%h want 1/%h", tr_rv[RD], tr_rdat[RD], ra[15:0]); end
  endtask

  task automatic test_reset_vs_valid;
    bus.req_we = 1'b0; bus.req_addr = 18'h12345; bus.req_be = 2'b11; bus.req_valid = 1'b1;
    greset = 1'b1;
    @(negedge clk);
    cmp_n++; if ({ramcs, ramoe} !== 2'b11) begin fail_n++;
      $display("FAIL rst_vs_valid_pins: got cs/oe %b want 11", {ramcs, ramoe}); end
    cmp_n++; if (dbg_state !== ST_IDLE) begin fail_n++;
      $display("FAIL rst_vs_valid_state: got %0d want %0d", dbg_state, ST_IDLE); end
    greset = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    be;
    int            len;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, (1 << AW) - 1));
      d  = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      txn(we, a, d, be, 1'b0);
      if (!tr_ok) return;
      len = m_len(we);
      for (int k = 0; k <= len; k++) begin
        cmp_n++; if (tr_pins[k] !== m_pins(we, be, k)) begin fail_n++;
          $display("FAIL rnd_pins n=%0d k=%0d: got %b want %b", n, k, tr_pins[k], m_pins(we, be, k)); end
        cmp_n++; if (tr_adr[k] !== ((k < len) ? a : '0)) begin fail_n++;
          $display("FAIL rnd_adr n=%0d k=%0d: got %h want %h", n, k, tr_adr[k], (k < len) ? a : '0); end
        cmp_n++; if (tr_drv[k] !== m_drive(we, k)) begin fail_n++;
          $display("FAIL rnd_drive n=%0d k=%0d: got %b want %b", n, k, tr_drv[k], m_drive(we, k)); end
        if (m_drive(we, k)) begin
          cmp_n++; if (tr_dat[k] !== d) begin fail_n++;
            $display("FAIL rnd_dat n=%0d k=%0d: got %h want %h", n, k, tr_dat[k], d); end
        end
        cmp_n++; if ((tr_drv[k] && !tr_pins[k][2]) || (!tr_pins[k][2] && !tr_pins[k][3])) begin fail_n++;
          $display("FAIL rnd_contention n=%0d k=%0d: got pins %b drive %b want no overlap", n, k, tr_pins[k], tr_drv[k]); end
        cmp_n++; if ({tr_rv[k], tr_wd[k]} !== {(k == len) && !we, (k == len) && we}) begin fail_n++;
          $display("FAIL rnd_pulses n=%0d k=%0d: got %b%b want %b%b", n, k, tr_rv[k], tr_wd[k],
                   (k == len) && !we, (k == len) && we); end
        cmp_n++; if (tr_rdy[k] !== (k == len)) begin fail_n++;
          $display("FAIL rnd_ready n=%0d k=%0d: got %b want %b", n, k, tr_rdy[k], k == len); end
      end
      if (!we && be != 2'b00) begin
        cmp_n++; if ((tr_rdat[len] & m_mask(be)) !== (a[15:0] & m_mask(be))) begin fail_n++;
          $display("FAIL rnd_rdata n=%0d: got %h want %h (mask %h)", n, tr_rdat[len] & m_mask(be),
                   a[15:0] & m_mask(be), m_mask(be)); end
      end
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_read;
    test_byte_read;
    test_write;
    test_back_to_back;
    test_stall;
    test_reset_mid_write;
    test_reset_vs_valid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
